// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, default memory geometry.
// Used by the fetch, execute, memory and writeback stages.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int DMEM_BYTES_DEF = 1024;
  localparam int DMEM_AW_DEF    = 10;

  function automatic logic is_mem_read(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_RET) || (icode == I_POPQ);
  endfunction

  function automatic logic is_mem_write(input logic [3:0] icode);
    return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
  endfunction

endpackage

// File: rtl/dmem_bytes.sv
// Byte-addressed data memory: 8-byte little-endian combinational read, 8-byte write, async clear.
// Optional debug read port enabled by DMEM_DBG_PORT_EN.
module dmem_bytes
  import y86_pkg::*;
#(
  parameter int DMEM_BYTES = DMEM_BYTES_DEF,
  parameter int AW         = DMEM_AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [63:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [63:0]   rdata_o
`ifdef DMEM_DBG_PORT_EN
  ,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [63:0]   dbg_data_o
`endif
);

  localparam logic [AW:0] LIMIT = (AW+1)'(DMEM_BYTES);

  logic [7:0] mem_q [DMEM_BYTES];

  // Byte array: cleared by reset, 8-byte store when enabled (caller guarantees no wrap)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DMEM_BYTES; i++) mem_q[i] <= 8'h00;
    end else if (we_i) begin
      for (int i = 0; i < 8; i++) mem_q[waddr_i + AW'(i)] <= wdata_i[8*i +: 8];
    end
  end

  // Main read port; bytes past the end of the array read as zero
  always_comb begin
    logic [AW:0] idx;
    rdata_o = 64'h0;
    idx     = '0;
    for (int i = 0; i < 8; i++) begin
      idx = {1'b0, raddr_i} + (AW+1)'(i);
      if (idx < LIMIT) rdata_o[8*i +: 8] = mem_q[idx[AW-1:0]];
      else             rdata_o[8*i +: 8] = 8'h00;
    end
  end

`ifdef DMEM_DBG_PORT_EN
  // Debug read port, independent of processor status
  always_comb begin
    logic [AW:0] didx;
    dbg_data_o = 64'h0;
    didx       = '0;
    for (int i = 0; i < 8; i++) begin
      didx = {1'b0, dbg_addr_i} + (AW+1)'(i);
      if (didx < LIMIT) dbg_data_o[8*i +: 8] = mem_q[didx[AW-1:0]];
      else              dbg_data_o[8*i +: 8] = 8'h00;
    end
  end
`endif

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: op decode, address select, bounds/status logic and sticky status.
// Optional debug read port enabled by DMEM_DBG_PORT_EN.
module memory_stage
  import y86_pkg::*;
#(
  parameter int DMEM_BYTES = DMEM_BYTES_DEF,
  parameter int AW         = DMEM_AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    icode,
  input  logic          instr_valid,
  input  logic          imem_error,
  input  logic [63:0]   valE,
  input  logic [63:0]   valA,
  input  logic [63:0]   valP,
  output logic [63:0]   valM,
  output logic [2:0]    stat,
  output logic          halted
`ifdef DMEM_DBG_PORT_EN
  ,
  input  logic [AW-1:0] dbg_addr,
  output logic [63:0]   dbg_data
`endif
);

  localparam logic [63:0] ADDR_MAX = 64'(DMEM_BYTES - 8);

  logic        rd_op_s, wr_op_s, addr_err_s, we_s;
  logic [63:0] addr_s, wdata_s, rdata_s;
  logic [2:0]  stat_now_s;
  logic [2:0]  stat_q, stat_d;
  logic        halted_q, halted_d;

  // Decode, address mux, bounds check (full 64-bit compare) and status priority
  always_comb begin
    rd_op_s    = is_mem_read(icode);
    wr_op_s    = is_mem_write(icode);
    addr_s     = ((icode == I_RET) || (icode == I_POPQ)) ? valA : valE;
    wdata_s    = (icode == I_CALL) ? valP : valA;
    addr_err_s = (rd_op_s || wr_op_s) && (addr_s > ADDR_MAX);
    if (imem_error)           stat_now_s = STAT_ADR;
    else if (!instr_valid)    stat_now_s = STAT_INS;
    else if (addr_err_s)      stat_now_s = STAT_ADR;
    else if (icode == I_HALT) stat_now_s = STAT_HLT;
    else                      stat_now_s = STAT_AOK;
    we_s = wr_op_s && (stat_now_s == STAT_AOK) && !halted_q;
    if (rd_op_s && (stat_now_s == STAT_AOK) && !halted_q) valM = rdata_s;
    else                                                  valM = 64'h0;
    stat   = halted_q ? stat_q : stat_now_s;
    halted = halted_q;
  end

  dmem_bytes #(.DMEM_BYTES(DMEM_BYTES), .AW(AW)) u_dmem (
    .clk        (clk),
    .rst        (rst),
    .we_i       (we_s),
    .waddr_i    (addr_s[AW-1:0]),
    .wdata_i    (wdata_s),
    .raddr_i    (addr_s[AW-1:0]),
    .rdata_o    (rdata_s)
`ifdef DMEM_DBG_PORT_EN
    ,
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
`endif
  );

  // First non-AOK status is captured and then frozen until reset
  always_comb begin
    stat_d   = stat_q;
    halted_d = halted_q;
    if (!halted_q && (stat_now_s != STAT_AOK)) begin
      stat_d   = stat_now_s;
      halted_d = 1'b1;
    end else begin
      stat_d   = stat_q;
      halted_d = halted_q;
    end
  end

  // Sticky status register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q   <= STAT_AOK;
      halted_q <= 1'b0;
    end else begin
      stat_q   <= stat_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a byte-level reference model predicts valM/stat/halted.
// Debug-port checks are included when DMEM_DBG_PORT_EN is defined.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode;
  logic        instr_valid, imem_error;
  logic [63:0] valE, valA, valP, valM;
  logic [2:0]  stat;
  logic        halted;
`ifdef DMEM_DBG_PORT_EN
  logic [9:0]  dbg_addr;
  logic [63:0] dbg_data;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] valm;
    logic [2:0]  stat;
    logic        halted;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] m_mem [1024];
  logic [2:0] m_stat;
  logic       m_halt;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk         (clk),
    .rst         (rst),
    .icode       (icode),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .valE        (valE),
    .valA        (valA),
    .valP        (valP),
    .valM        (valM),
    .stat        (stat),
    .halted      (halted)
`ifdef DMEM_DBG_PORT_EN
    ,
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [63:0] addr);
    logic [63:0] d = 64'h0;
    logic [63:0] a;
    for (int i = 0; i < 8; i++) begin
      a = addr + 64'(i);
      if (a < 64'd1024) d[8*i +: 8] = m_mem[a[9:0]];
    end
    return d;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;
    m_stat = 3'd1;
    m_halt = 1'b0;
  endtask

  // One instruction: drive at negedge, predict, compare mid-cycle, update model at posedge.
  task automatic do_op(input string tag, input logic [3:0] ic, input logic vld, input logic ime,
                       input logic [63:0] ve, input logic [63:0] va, input logic [63:0] vp);
    logic rd, wr;
    logic [63:0] addr, wd;
    logic [2:0] sn;
    exp_t e;
    @(negedge clk);
    icode = ic; instr_valid = vld; imem_error = ime; valE = ve; valA = va; valP = vp;
    rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    wr   = (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
    addr = ((ic == 4'h9) || (ic == 4'hB)) ? va : ve;
    wd   = (ic == 4'h8) ? vp : va;
    if (ime)                              sn = 3'd3;
    else if (!vld)                        sn = 3'd4;
    else if ((rd || wr) && addr > 64'd1016) sn = 3'd3;
    else if (ic == 4'h0)                  sn = 3'd2;
    else                                  sn = 3'd1;
    e.tag    = tag;
    e.stat   = m_halt ? m_stat : sn;
    e.valm   = (!m_halt && sn == 3'd1 && rd) ? m_read(addr) : 64'h0;
    e.halted = m_halt;
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    check_eq({e.tag, ".valM"}, valM, e.valm);
    check_eq({e.tag, ".stat"}, 64'(stat), 64'(e.stat));
    check_eq({e.tag, ".halted"}, 64'(halted), 64'(e.halted));
    @(posedge clk);
    if (!m_halt && sn == 3'd1 && wr)
      for (int i = 0; i < 8; i++) m_mem[addr[9:0] + 10'(i)] = wd[8*i +: 8];
    if (!m_halt && sn != 3'd1) begin
      m_stat = sn;
      m_halt = 1'b1;
    end
    #1;
    check_eq({tag, ".halted_after"}, 64'(halted), 64'(m_halt));
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; icode = 4'h1; instr_valid = 1'b1; imem_error = 1'b0;
    #1;
    m_clear();
    check_eq({tag, ".stat"}, 64'(stat), 64'(3'd1));
    check_eq({tag, ".halted"}, 64'(halted), 64'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; icode = 4'h1; instr_valid = 1'b1; imem_error = 1'b0;
    valE = 64'h0; valA = 64'h0; valP = 64'h0;
`ifdef DMEM_DBG_PORT_EN
    dbg_addr = 10'h0;
`endif
    m_clear();
    #2;
    check_eq("reset.valM", valM, 64'h0);
    check_eq("reset.stat", 64'(stat), 64'(3'd1));
    check_eq("reset.halted", 64'(halted), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    do_op("st",     4'h4, 1'b1, 1'b0, 64'h10, 64'h1122334455667788, 64'h0);
    do_op("ld",     4'h5, 1'b1, 1'b0, 64'h10, 64'h0, 64'h0);
    check_eq("ld.literal", valM, 64'h1122334455667788);
    do_op("ld_un",  4'h5, 1'b1, 1'b0, 64'h11, 64'h0, 64'h0);
    do_op("push",   4'hA, 1'b1, 1'b0, 64'h1F8, 64'hABCD, 64'h0);
    do_op("pop",    4'hB, 1'b1, 1'b0, 64'h0, 64'h1F8, 64'h0);
    check_eq("pop.literal", valM, 64'hABCD);
    do_op("call",   4'h8, 1'b1, 1'b0, 64'h1F0, 64'h99, 64'h42);
    do_op("ret",    4'h9, 1'b1, 1'b0, 64'h0, 64'h1F0, 64'h0);
    check_eq("ret.literal", valM, 64'h42);
    do_op("nop",    4'h1, 1'b1, 1'b0, 64'h10, 64'h10, 64'h0);
    do_op("st_top", 4'h4, 1'b1, 1'b0, 64'd1016, 64'hCAFEF00D_DEADBEEF, 64'h0);
    do_op("ld_top", 4'h5, 1'b1, 1'b0, 64'd1016, 64'h0, 64'h0);
`ifdef DMEM_DBG_PORT_EN
    dbg_addr = 10'd1020; #1;
    check_eq("dbg_end", dbg_data, m_read(64'd1020));
    dbg_addr = 10'h10; #1;
    check_eq("dbg_byte10", 64'(dbg_data[7:0]), 64'h88);
`endif
    do_op("ld_oob", 4'h5, 1'b1, 1'b0, 64'd1017, 64'h0, 64'h0);
    do_op("oob_hold", 4'h1, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0);

    pulse_reset("rst1");
    do_op("st_huge", 4'h4, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_0000, 64'h5555, 64'h0);
`ifdef DMEM_DBG_PORT_EN
    dbg_addr = 10'h0; #1;
    check_eq("dbg_huge", dbg_data, 64'h0);
`endif

    pulse_reset("rst2");
    do_op("halt",    4'h0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0);
    do_op("st_halt", 4'h4, 1'b1, 1'b0, 64'h20, 64'h7777, 64'h0);
    do_op("ld_halt", 4'h5, 1'b1, 1'b0, 64'h10, 64'h0, 64'h0);
`ifdef DMEM_DBG_PORT_EN
    dbg_addr = 10'h20; #1;
    check_eq("dbg_halt", dbg_data, 64'h0);
`endif

    pulse_reset("rst3");
    do_op("prio_adr", 4'h0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0);
    pulse_reset("rst4");
    do_op("prio_ins", 4'h1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);

    // Async reset mid-cycle while halted, with data in memory
    pulse_reset("rst5");
    do_op("st_a", 4'h4, 1'b1, 1'b0, 64'h10, 64'h0123456789ABCDEF, 64'h0);
    do_op("st_b", 4'hA, 1'b1, 1'b0, 64'h100, 64'hFEED, 64'h0);
    do_op("halt2", 4'h0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0);
    @(negedge clk);
    icode = 4'h5; instr_valid = 1'b1; imem_error = 1'b0; valE = 64'h10;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    m_clear();
    check_eq("async.stat", 64'(stat), 64'(3'd1));
    check_eq("async.halted", 64'(halted), 64'h0);
    check_eq("async.valM", valM, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    do_op("post_a", 4'h5, 1'b1, 1'b0, 64'h10, 64'h0, 64'h0);
    do_op("post_b", 4'hB, 1'b1, 1'b0, 64'h0, 64'h100, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
